sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024, byte address of data-memory word 0.
REQ-002 SHALL have parameter SRAM_AW, default 18, SRAM halfword address width.
REQ-003 SHALL have port clock, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, word write request from the MEM stage, held until ready.
REQ-006 SHALL have port rd_en, input, 1, word read request from the MEM stage, held until ready.
REQ-007 SHALL have port address, input, 32, byte address, word aligned.
REQ-008 SHALL have port write_data, input, 32, store data.
REQ-009 SHALL have port read_data, output, 32, registered load data.
REQ-010 SHALL have port ready, output, 1, low means freeze the pipeline.
REQ-011 SHALL have port SRAM_ADDR, output, 18, halfword address.
REQ-012 SHALL have port SRAM_DQ, inout, 16, data bus.
REQ-013 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N and SRAM_OE_N, each an output of width 1, active-low SRAM controls.

Function
REQ-014 SHALL compute offset = address - BASE_ADDR and word = offset[18:2]; the low halfword address is {word,0} and the high halfword address is {word,1}, and addresses outside the range wrap modulo 2^18.
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE: IDLE goes to LOW when (rd_en|wr_en), LOW goes to HIGH, HIGH goes to DONE, and DONE goes to IDLE unconditionally.
REQ-016 SHALL drive ready = ~(rd_en|wr_en) | (state==DONE) combinationally, so a request sees ready high in the 4th cycle (IDLE, LOW, HIGH, DONE).
REQ-017 SHALL give wr_en priority when rd_en and wr_en are both high, treating the access as a write only.
REQ-018 SHALL, during LOW, drive SRAM_ADDR with the low address; for a write, drive SRAM_DQ with write_data[15:0] and SRAM_WE_N=0.
REQ-019 SHALL, during HIGH, drive SRAM_ADDR with the high address; for a write, drive SRAM_DQ with write_data[31:16] and SRAM_WE_N=0.
REQ-020 SHALL latch the address and operation type on the IDLE to LOW transition, so input changes mid-sequence have no effect.
REQ-021 SHALL, for a read, capture SRAM_DQ into read_data[15:0] at the end of LOW and into read_data[31:16] at the end of HIGH, and hold read_data until the next read completes.
REQ-022 SHALL drive SRAM_DQ to high-Z in every state other than a write in LOW or HIGH, and drive SRAM_WE_N=1 outside a write in LOW or HIGH.
REQ-023 SHALL drive SRAM_CE_N=0, SRAM_OE_N=0, SRAM_UB_N=0 and SRAM_LB_N=0 constantly.
REQ-024 SHALL complete a started sequence even if the request drops mid-sequence, with no extra ready pulse in IDLE.
REQ-025 SHALL, for back-to-back requests, start the next sequence from IDLE one cycle after DONE, with no request lost or duplicated.
REQ-026 SHALL drive SRAM_ADDR to 0 in IDLE and DONE.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set state=IDLE and read_data=0, giving SRAM_WE_N=1, SRAM_DQ=Z and SRAM_ADDR=0, with ready following REQ-016.
REQ-028 SHALL, on reset mid-sequence, abort immediately, drive no further write strobe, and leave a partial write permitted in SRAM.

Configuration
REQ-029 SHALL, when macro SRAM_WAIT_STATE_EN is defined, add states LOW_W after LOW and HIGH_W after HIGH, holding the address, data and WE_N of the preceding state, moving read capture to the end of LOW_W and HIGH_W, and making ready latency 6 cycles.
REQ-030 SHALL, when SRAM_WAIT_STATE_EN is undefined, implement only IDLE, LOW, HIGH and DONE with a latency of 4 cycles.

Verification
REQ-031 SHALL check that after reset: ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
REQ-032 SHALL check that a write at address=1024 with write_data=0xDEADBEEF gives SRAM_ADDR=0 with DQ=0xBEEF and WE_N=0, then SRAM_ADDR=1 with DQ=0xDEAD and WE_N=0, then ready=1 in cycle 4.
REQ-033 SHALL check that a read at address=1028, with the SRAM model holding [2]=0x5678 and [3]=0x1234, gives read_data=0x12345678 while ready=1, with SRAM_DQ never driven by the DUT.
REQ-034 SHALL check that rd_en=wr_en=1 at address 1032 with data 0xCAFEF00D performs a write only, and a later read returns 0xCAFEF00D.
REQ-035 SHALL check that rst=1 in HIGH of a write to 1036 gives state IDLE and WE_N=1 next cycle, and that a subsequent read of 1036 completes normally.
REQ-036 SHALL check that with SRAM_WAIT_STATE_EN defined, a write then a read at 1024 have ready latency 6 each, with each SRAM_ADDR value held 2 cycles.

Source files
------------

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Splits each 32-bit data-memory access into two 16-bit SRAM
//               halfword cycles. Optional macro SRAM_WAIT_STATE_EN adds one
//               wait state per halfword.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int BASE_ADDR = 1024,
    parameter int SRAM_AW   = 18
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW    = 3'd1,
        LOW_W  = 3'd2,
        HIGH   = 3'd3,
        HIGH_W = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             r_state;
    logic [SRAM_AW-2:0] r_word;
    logic               r_is_write;
    logic [31:0]        r_wdata;

    logic [31:0]        w_offset;
    logic [SRAM_AW-2:0] w_word;
    logic               w_req;
    logic               w_drive;
    logic [15:0]        w_dq_out;
    logic [SRAM_AW-1:0] w_addr;
    logic               w_unused;

    // Out-of-range addresses simply wrap because only the low offset bits are kept.
    assign w_offset = address - 32'(BASE_ADDR);
    assign w_word   = w_offset[SRAM_AW:2];
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign w_req    = rd_en | wr_en;

    assign ready     = ~w_req | (r_state == DONE);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = w_addr;
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_DQ   = w_drive ? w_dq_out : 16'bz;

    always_comb begin
        w_addr   = '0;
        w_drive  = 1'b0;
        w_dq_out = r_wdata[15:0];
        case (r_state)
            LOW: begin
                w_addr  = {r_word, 1'b0};
                w_drive = r_is_write;
            end
            HIGH: begin
                w_addr   = {r_word, 1'b1};
                w_drive  = r_is_write;
                w_dq_out = r_wdata[31:16];
            end
`ifdef SRAM_WAIT_STATE_EN
            LOW_W: begin
                w_addr  = {r_word, 1'b0};
                w_drive = r_is_write;
            end
            HIGH_W: begin
                w_addr   = {r_word, 1'b1};
                w_drive  = r_is_write;
                w_dq_out = r_wdata[31:16];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
            read_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state    <= LOW;
                        r_word     <= w_word;
                        r_is_write <= wr_en;
                        r_wdata    <= write_data;
                    end
                end
`ifdef SRAM_WAIT_STATE_EN
                LOW:    r_state <= LOW_W;
                LOW_W: begin
                    r_state <= HIGH;
                    if (!r_is_write) read_data[15:0] <= SRAM_DQ;
                end
                HIGH:   r_state <= HIGH_W;
                HIGH_W: begin
                    r_state <= DONE;
                    if (!r_is_write) read_data[31:16] <= SRAM_DQ;
                end
`else
                LOW: begin
                    r_state <= HIGH;
                    if (!r_is_write) read_data[15:0] <= SRAM_DQ;
                end
                HIGH: begin
                    r_state <= DONE;
                    if (!r_is_write) read_data[31:16] <= SRAM_DQ;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Scoreboard bench for sram_controller with a 16-entry SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

`ifdef SRAM_WAIT_STATE_EN
    localparam int c_rep = 2;
`else
    localparam int c_rep = 1;
`endif
    localparam int c_lat = 2 * c_rep + 2;

    typedef struct packed {
        logic [17:0] addr;
        logic        we_n;
        logic [15:0] dq;
        logic        chk_dq;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    logic [15:0] mem [0:15];
    logic        mem_init;
    logic        force_en;
    logic [15:0] force_val;

    int          checks = 0;
    int          errors = 0;
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .SRAM_AW(18)) dut (
        .clock      (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n)
    );

    // Asynchronous-read SRAM model; force_en substitutes a probe pattern.
    assign sram_dq = (we_n && !oe_n && !ce_n) ?
                     (force_en ? force_val : mem[sram_addr[3:0]]) : 16'bz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[2] <= 16'h5678;
            mem[3] <= 16'h1234;
        end else if (!we_n && !ce_n) begin
            mem[sram_addr[3:0]] <= sram_dq;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller is #1 after a rising edge; returns #1 after the edge leaving DONE.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input int drop_at);
        logic [31:0] off;
        logic [17:0] base;
        logic [17:0] a;
        logic        dropped;
        beat_t       e;
        off  = addr - 32'd1024;
        base = {off[18:2], 1'b0};
        beat_q.push_back(beat_t'{addr: 18'd0, we_n: 1'b1, dq: 16'd0, chk_dq: 1'b0});
        for (int k = 0; k < 2 * c_rep; k++) begin
            a = base | 18'((k >= c_rep) ? 1 : 0);
            if (wr)
                beat_q.push_back(beat_t'{addr: a, we_n: 1'b0,
                                 dq: (k >= c_rep) ? data[31:16] : data[15:0], chk_dq: 1'b1});
            else
                beat_q.push_back(beat_t'{addr: a, we_n: 1'b1, dq: mem[a[3:0]], chk_dq: 1'b1});
        end
        beat_q.push_back(beat_t'{addr: 18'd0, we_n: 1'b1, dq: 16'd0, chk_dq: 1'b0});
        if (rd && !wr) rd_q.push_back(data);

        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wr ? data : 32'hFFFF_FFFF;
        dropped    = 1'b0;
        for (int n = 1; n <= c_lat; n++) begin
            @(negedge clk);
            e = beat_q.pop_front();
            check_val("sram_addr", 64'(sram_addr), 64'(e.addr));
            check_val("we_n", 64'(we_n), 64'(e.we_n));
            if (e.chk_dq) check_val("sram_dq", 64'(sram_dq), 64'(e.dq));
            check_val("ready", 64'(ready), 64'((n == c_lat) || dropped));
            if (n == c_lat && rd && !wr) check_val("read_data", 64'(read_data), 64'(rd_q.pop_front()));
            @(posedge clk);
            #1;
            if (n == drop_at) begin
                wr_en      = 1'b0;
                rd_en      = 1'b0;
                address    = 32'h0000_0F00;
                write_data = 32'h1111_1111;
                dropped    = 1'b1;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        mem_init   = 1'b1;
        force_en   = 1'b1;
        force_val  = 16'hA5A5;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        // Reset state; bus must be undriven by the DUT (probe patterns pass through)
        @(negedge clk);
        check_val("rst_ready", 64'(ready), 64'd1);
        check_val("rst_we_n", 64'(we_n), 64'd1);
        check_val("rst_addr", 64'(sram_addr), 64'd0);
        check_val("rst_read_data", 64'(read_data), 64'd0);
        check_val("rst_dq_a5", 64'(sram_dq), 64'hA5A5);
        check_val("ctrl_n", 64'({ce_n, oe_n, ub_n, lb_n}), 64'd0);
        force_val = 16'h5A5A;
        @(negedge clk);
        check_val("rst_dq_5a", 64'(sram_dq), 64'h5A5A);
        force_en = 1'b0;
        @(posedge clk);
        #1;

        do_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 0);
        do_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 0);
        do_access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 0);
        check_val("rd_hold", 64'(read_data), 64'h1234_5678);
        do_access(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 0);
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 0);

        // Reset during the first HIGH cycle of a write to 1036
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'h0BAD_F00D;
        repeat (1 + c_rep) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check_val("abort_we_n", 64'(we_n), 64'd1);
        check_val("abort_addr", 64'(sram_addr), 64'd0);
        check_val("abort_read_data", 64'(read_data), 64'd0);
        check_val("abort_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b1, 32'd1036, {mem[7], mem[6]}, 0);

        // Requests dropped mid-sequence still complete on latched address/data
        do_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 2);
        do_access(1'b1, 1'b0, 32'd1040, 32'h9876_5432, 1);
        do_access(1'b0, 1'b1, 32'd1040, 32'h9876_5432, 0);

        // Below BASE_ADDR wraps to the top of the SRAM
        do_access(1'b1, 1'b0, 32'd1020, 32'h1357_2468, 0);
        do_access(1'b0, 1'b1, 32'd1020, 32'h1357_2468, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
